// File: rtl/seq_pattern_gen.sv
// Pattern generator feeding the LED sequencer pipeline: run/pause/step FSM, prescaled advance, four modes.
// Latency: dout and tick update together on the advancing edge; first RUN advance comes DIV clks after entry.
module seq_pattern_gen #(
    parameter int          N   = 4,
    parameter int          DIV = 4,
    parameter logic [N-1:0] INI = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         step,
    input  logic [1:0]   mode,
    input  logic [N-1:0] pattern,
    output logic [N-1:0] dout,
    output logic         tick,
    output logic         busy
);

    localparam int             PW   = $clog2(DIV);
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state_q;
    logic [N-1:0]    dout_q;
    logic [N-1:0]    seed_q;
    logic [PW-1:0]   presc_q;
    logic            dir_left_q;
    logic            tick_q;
    logic            busy_q;
    logic            step_q;

    logic [N-1:0]    adv_d;
    logic            dir_left_d;

    // Next pattern word for whichever mode is sampled on the advancing edge.
    always_comb begin
        adv_d      = dout_q;
        dir_left_d = dir_left_q;
        case (mode)
            2'd0: adv_d = (dout_q == seed_q) ? ~seed_q : seed_q;
            2'd1: adv_d = {dout_q[N-2:0], dout_q[N-1]};
            2'd2: adv_d = {dout_q[0], dout_q[N-1:1]};
            default: begin
                if (dout_q == '0)
                    adv_d = {{(N-1){1'b0}}, 1'b1};
                else if (dir_left_q)
                    adv_d = dout_q << 1;
                else
                    adv_d = dout_q >> 1;
                // Flip as soon as the moving bit lands on an end so no position is skipped.
                if (dir_left_q && adv_d[N-1])
                    dir_left_d = 1'b0;
                else if (!dir_left_q && adv_d[0])
                    dir_left_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            dout_q     <= INI;
            seed_q     <= INI;
            presc_q    <= '0;
            dir_left_q <= 1'b1;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            step_q <= step;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        dout_q     <= pattern;
                        seed_q     <= pattern;
                        dir_left_q <= 1'b1;
                        presc_q    <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= PAUSE;
                        presc_q <= '0;
                    end else if (presc_q == LAST) begin
                        dout_q     <= adv_d;
                        dir_left_q <= dir_left_d;
                        tick_q     <= 1'b1;
                        presc_q    <= '0;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dout_q  <= INI;
                    end else if (start) begin
                        state_q <= RUN;
                        presc_q <= '0;
                    end else if (step && !step_q) begin
                        dout_q     <= adv_d;
                        dir_left_q <= dir_left_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dout_q  <= INI;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign tick = tick_q;
    assign busy = busy_q;

endmodule
